// File: rtl/fifo_align_wr_arb.sv
// Packet-level round-robin arbiter for the write port of a 64x16 FIFO.
// Grants one requester per packet, with a MAX_WORDS packet-length limit.
// Ports:
//   clk, rst     - write clock and synchronous active-high reset
//   i_req/i_data - per-requester valid and 16-bit data slices
//   i_last       - per-requester end-of-packet flag
//   o_ack        - word consumed this cycle (combinational)
//   o_wr_en      - FIFO write enable (combinational)
//   o_wr_data    - FIFO write data (granted requester's slice)
//   i_full       - FIFO full
//   o_busy       - packet in progress (registered)
//   o_grant      - current or last granted index (registered)
//   o_err_trunc  - one-cycle pulse after a forced packet cut (registered)
module fifo_align_wr_arb #(
  parameter int N_REQ     = 4,
  parameter int N_REQ_log = 2,
  parameter int MAX_WORDS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       i_req,
  input  logic [N_REQ*16-1:0]    i_data,
  input  logic [N_REQ-1:0]       i_last,
  output logic [N_REQ-1:0]       o_ack,
  output logic                   o_wr_en,
  output logic [15:0]            o_wr_data,
  input  logic                   i_full,
  output logic                   o_busy,
  output logic [N_REQ_log-1:0]   o_grant,
  output logic                   o_err_trunc
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam logic [5:0] CNT_MAX = 6'(MAX_WORDS - 1);
  localparam logic [N_REQ_log-1:0] RR_RST = N_REQ_log'(N_REQ - 1);

  logic [0:0]           r_state;
  logic [N_REQ_log-1:0] r_g;
  logic [N_REQ_log-1:0] r_rr;
  logic [5:0]           r_cnt;
  logic                 r_err;

  logic [15:0]          w_slice [N_REQ];
  logic                 w_found;
  logic [N_REQ_log-1:0] w_pick;
  logic [N_REQ_log-1:0] w_pos;
  logic                 w_xfer;

  for (genvar n = 0; n < N_REQ; n++) begin : g_slice
    assign w_slice[n] = i_data[16*n +: 16];
  end

  // Round-robin search: first set request starting at rr+1, wrapping.
  always_comb begin
    int t;
    t       = 0;
    w_found = 1'b0;
    w_pick  = '0;
    w_pos   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      t = int'(r_rr) + i;
      if (t >= N_REQ) t = t - N_REQ;
      w_pos = N_REQ_log'(t);
      if (!w_found && i_req[w_pos]) begin
        w_found = 1'b1;
        w_pick  = w_pos;
      end
    end
  end

  assign w_xfer      = (r_state == S_BUSY) & i_req[r_g] & ~i_full;
  assign o_wr_en     = w_xfer;
  assign o_ack       = N_REQ'(w_xfer) << r_g;
  assign o_wr_data   = w_slice[r_g];
  assign o_busy      = (r_state == S_BUSY);
  assign o_grant     = r_g;
  assign o_err_trunc = r_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_g     <= '0;
      r_rr    <= RR_RST;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_g     <= w_pick;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_xfer) begin
            if (i_last[r_g]) begin
              r_state <= S_IDLE;
              r_rr    <= r_g;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_MAX) begin
              // Forced end: this word is the packet's last one.
              r_state <= S_IDLE;
              r_rr    <= r_g;
              r_cnt   <= '0;
              r_err   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 6'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_align_wr_arb.md
# fifo_align_wr_arb

Packet-level round-robin arbiter that shares the write port of a 64x16 mesochronous FIFO among N_REQ local requesters. It sits entirely in the FIFO write clock domain, between the requesters and the FIFO's `i_wr_en` / `i_wr_data` / `o_full` pins. The arbiter grants one requester at a time and holds the grant until that requester's end-of-packet word is accepted, so packets from different requesters never interleave in the FIFO. It also enforces a maximum packet length.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `N_REQ_log`, default 2: ceil(log2(N_REQ)), the width of the grant index.
- `MAX_WORDS`, default 16: maximum words per packet, 2..64.
- `clk`, input, 1: write-side clock, the same clock as the FIFO's `clk_wr`.
- `rst`, input, 1: synchronous, active-high reset.
- `i_req`, input, N_REQ: per-requester valid; word available on `i_data`.
- `i_data`, input, N_REQ*16: requester n drives bits [16n+15:16n].
- `i_last`, input, N_REQ: the current word of requester n is the end of its packet.
- `o_ack`, output, N_REQ: word of requester n consumed this cycle. Combinational.
- `o_wr_en`, output, 1: FIFO write enable. Combinational.
- `o_wr_data`, output, 16: FIFO write data, i.e. the granted requester's `i_data` slice.
- `i_full`, input, 1: FIFO `o_full`.
- `o_busy`, output, 1: a packet is in progress (state BUSY). Registered.
- `o_grant`, output, N_REQ_log: index of the current or last granted requester. Registered.
- `o_err_trunc`, output, 1: one-cycle pulse when a packet is force-terminated at MAX_WORDS. Registered.

## Operation
- The state machine has two states: IDLE and BUSY. All state is in registers: state, grant index `g`, round-robin pointer `rr`, word counter `cnt` (6 bits, 0..MAX_WORDS-1), and `o_err_trunc`.
- Reset values:
  - state = IDLE, `g` = 0, `rr` = N_REQ-1 (so requester 0 wins first), `cnt` = 0.
  - `o_busy` = 0, `o_grant` = 0, `o_err_trunc` = 0, `o_ack` = 0, `o_wr_en` = 0.
- **IDLE:**
  - No writes are made; `o_ack` = 0.
  - If any `i_req` bit is set, pick the first set bit searching from `rr+1` upward, wrapping modulo N_REQ.
  - Register its index into `g`, clear `cnt`, and go to BUSY.
  - `i_full` does not block the grant.
- **BUSY:**
  - `xfer` = `i_req[g]` & ~`i_full`.
  - `o_wr_en` = `xfer`; `o_ack[g]` = `xfer`; all other ack bits are 0. `o_wr_data` = slice `g` of `i_data`.
  - On `xfer` with `i_last[g]`=1: go to IDLE, set `rr` = `g`, clear `cnt`.
  - On `xfer` with `i_last[g]`=0 and `cnt` = MAX_WORDS-1 (the word is written anyway, as the last one): go to IDLE, set `rr` = `g`, and pulse `o_err_trunc` the next cycle. The requester's remaining words are treated as a new packet under a later grant.
  - On any other `xfer`: `cnt` <= `cnt`+1.
  - If `i_req[g]`=0, or `i_full`=1, the arbiter holds BUSY and `g` with no write. There is no timeout and no preemption.
- Requesters must not change `i_data` or `i_last` while `i_req`=1 and `o_ack`=0.
- Requests from non-granted requesters are ignored until the next IDLE cycle.
- Reset asserted mid-packet: starting the next cycle, `o_wr_en` = 0 and state = IDLE. The partial packet already in the FIFO is not removed. The FIFO is reset by its own `rst_wr`.

## Timing
- Grant latency: `i_req` seen in IDLE at cycle t leads to BUSY with `g` set at t+1. The first write can occur at t+1.
- Throughput: one word per cycle while BUSY, the granted request is held, and the FIFO is not full.
- Each packet costs one bubble cycle (IDLE) before the next grant. A P-word packet therefore occupies P+1 cycles minimum.
- `i_full` to `o_wr_en` is a combinational path with zero cycles of latency.
- `o_err_trunc` asserts for exactly one cycle, the cycle after the truncating write.

## Test plan
- **Single packet.** After reset, `i_req[2]`=1 with a 3-word packet 0xA001, 0xA002, 0xA003 (last on the third word).
  - `o_grant` = 2 at cycle 1.
  - `o_wr_en` is high on cycles 1-3 with that data.
  - `o_busy` falls at cycle 4.
- **Round-robin fairness.** All 4 requesters continuously send 2-word packets.
  - The grant order is 0, 1, 2, 3, 0, ...
  - Each packet takes 3 cycles; no words interleave between packets.
- **Full stall mid-packet.** Requester 1 sends a 4-word packet; `i_full`=1 for 5 cycles after word 2.
  - `o_wr_en` = 0 and `o_ack` = 0 during the stall; `o_grant` stays 1.
  - Words 3-4 are written after `i_full` drops.
- **Truncation.** MAX_WORDS=16; requester 0 streams 20 words with `i_last` set only on word 20.
  - Words 1-16 are written; `o_err_trunc` pulses once, the cycle after word 16.
  - Words 17-20 follow as a new packet, after other pending requesters have been served.
- **Reset mid-packet.** `rst` is asserted while 3 of 8 words are written.
  - `o_wr_en` = 0 and `o_busy` = 0 the next cycle.
  - After release, requester 0 is granted first.
- **Simultaneous events.** `i_req` = 0b1010 arrives in the same IDLE cycle as `rr` = 1.
  - Requester 3 is granted.
  - On its completion `rr` = 3, and requester 1 is granted next.
